// File: rtl/boolexpr_pkg.sv
// Shared types, sizes and the 4-in/5-out expression used by the
// expression block and the solver. No ports.
package boolexpr_pkg;

  localparam int N_IN   = 4;
  localparam int N_OUT  = 5;
  localparam int N_COMB = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  // Returns {y5,y4,y3,y2,y1} for {a,b,c,d}; a is bit 3.
  function automatic logic [N_OUT-1:0] eval(
    input logic [N_IN-1:0] abcd
  );
    logic a, b, c, d;
    logic [N_OUT-1:0] y;
    a = abcd[3];
    b = abcd[2];
    c = abcd[1];
    d = abcd[0];
    y[0] = (a & b) | (~c & d);
    y[1] = ~(a | b | c);
    y[2] = (a ^ b) & (c | d);
    y[3] = (a & ~b) | (b & ~c) | (c & ~a);
    y[4] = (a ^ b) | ~(c & d);
    return y;
  endfunction

endpackage

// File: rtl/boolexpr_solver_if.sv
// Request / solution-stream bundle of the solver.
// Request: req_valid, req_ready, target, mask.
// Stream: sol_valid, sol_ready, sol_abcd; done pulse.
// match_count exists only with BOOLEXPR_SOLVER_COUNT_EN.
interface boolexpr_solver_if;

  logic       req_valid;
  logic       req_ready;
  logic [4:0] target;
  logic [4:0] mask;
  logic       sol_valid;
  logic       sol_ready;
  logic [3:0] sol_abcd;
  logic       done;
`ifdef BOOLEXPR_SOLVER_COUNT_EN
  logic [4:0] match_count;
`endif

`ifdef BOOLEXPR_SOLVER_COUNT_EN
  modport master (
    output req_valid, target, mask, sol_ready,
    input  req_ready, sol_valid, sol_abcd, done,
    input  match_count
  );
  modport slave (
    input  req_valid, target, mask, sol_ready,
    output req_ready, sol_valid, sol_abcd, done,
    output match_count
  );
`else
  modport master (
    output req_valid, target, mask, sol_ready,
    input  req_ready, sol_valid, sol_abcd, done
  );
  modport slave (
    input  req_valid, target, mask, sol_ready,
    output req_ready, sol_valid, sol_abcd, done
  );
`endif

endinterface

// File: rtl/boolexpr_eval.sv
// Combinational wrapper of the shared expression.
// Ports: abcd in (a in bit 3), y out ({y5..y1}).
module boolexpr_eval
  import boolexpr_pkg::*;
(
  input  logic [N_IN-1:0]  abcd,
  output logic [N_OUT-1:0] y
);

  assign y = eval(abcd);

endmodule

// File: rtl/boolexpr_solver.sv
// Preimage finder: scans all 16 {a,b,c,d}, streams matches.
// Ports: clk, rst (sync, active-high), bus (slave modport).
// Macro BOOLEXPR_SOLVER_COUNT_EN adds match_count.
module boolexpr_solver
  import boolexpr_pkg::*;
(
  input logic              clk,
  input logic              rst,
  boolexpr_solver_if.slave bus
);

  state_t           state;
  logic [4:0]       idx;
  logic [N_OUT-1:0] target_q;
  logic [N_OUT-1:0] mask_q;
  logic [N_OUT-1:0] y;
  logic [N_IN-1:0]  cand;
  logic             hit;
  logic             free;
  logic             last;

  assign cand = idx[N_IN-1:0];

  boolexpr_eval u_eval (
    .abcd (cand),
    .y    (y)
  );

  assign hit  = ((y ^ target_q) & mask_q) == '0;
  // Output slot can take a beat if empty or emptying now.
  assign free = !bus.sol_valid || bus.sol_ready;
  assign last = idx == 5'(N_COMB - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      target_q      <= '0;
      mask_q        <= '0;
      bus.req_ready <= 1'b1;
      bus.sol_valid <= 1'b0;
      bus.sol_abcd  <= '0;
      bus.done      <= 1'b0;
`ifdef BOOLEXPR_SOLVER_COUNT_EN
      bus.match_count <= '0;
`endif
    end else begin
      bus.done <= 1'b0;
      if (bus.sol_valid && bus.sol_ready) begin
        bus.sol_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            target_q      <= bus.target;
            mask_q        <= bus.mask;
            idx           <= '0;
            bus.req_ready <= 1'b0;
            state         <= SCAN;
`ifdef BOOLEXPR_SOLVER_COUNT_EN
            bus.match_count <= '0;
`endif
          end
        end
        SCAN: begin
          // A match waits while the slot is full.
          if (!hit || free) begin
            if (hit) begin
              bus.sol_valid <= 1'b1;
              bus.sol_abcd  <= cand;
`ifdef BOOLEXPR_SOLVER_COUNT_EN
              bus.match_count <= bus.match_count + 5'd1;
`endif
            end
            idx <= idx + 5'd1;
            if (last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (free) begin
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boolexpr_solver.sv
// Self-checking bench for boolexpr_solver.
// Model: truth-table scoreboard built from the expressions.
module tb_boolexpr_solver;

  logic clk;
  logic rst;

  boolexpr_solver_if bus ();

  boolexpr_solver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int         cyc = 0;
  logic [3:0] exp_q[$];
  bit         busy = 0;
  int         t_acc = 0;
  bit         ready_always = 1;
  bit         post_rst = 0;
  int         popped = 0;
  bit         prev_hold = 0;
  logic [3:0] prev_abcd = '0;
  int         done_seen = 0;
  logic [15:0] obs_map = '0;

  bit stall_mode = 0;
  int stall_ph = 0;
  int scnt = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Bitmap of matching combinations, bit k = {a,b,c,d}==k.
  function automatic logic [15:0] model_map(
    input logic [4:0] t,
    input logic [4:0] m
  );
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      int a, b, c, d;
      logic [4:0] y;
      bit ok;
      a = (k >> 3) & 1;
      b = (k >> 2) & 1;
      c = (k >> 1) & 1;
      d = k & 1;
      y[0] = (a == 1 && b == 1) || (c == 0 && d == 1);
      y[1] = (a + b + c) == 0;
      y[2] = (a != b) && ((c + d) > 0);
      y[3] = !(a == b && b == c);
      y[4] = (a != b) || !(c == 1 && d == 1);
      ok = 1;
      for (int j = 0; j < 5; j++)
        if (m[j] && (y[j] != t[j])) ok = 0;
      r[k] = ok;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    logic [15:0] mp;
    cyc++;
    if (rst) begin
      exp_q.delete();
      busy      = 0;
      popped    = 0;
      post_rst  = 1;
      prev_hold = 0;
    end else begin
      if (post_rst) begin
        chk("rst_sol_valid", bus.sol_valid, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_done", bus.done, 0);
        chk("rst_sol_abcd", bus.sol_abcd, 0);
        post_rst = 0;
      end
      chk("req_ready", bus.req_ready, !busy);
      if (prev_hold) begin
        chk("hold_valid", bus.sol_valid, 1);
        chk("hold_abcd", bus.sol_abcd, prev_abcd);
      end
`ifdef BOOLEXPR_SOLVER_COUNT_EN
      chk("match_count", bus.match_count,
          popped + (bus.sol_valid ? 1 : 0));
`endif
      if (bus.sol_valid) begin
        chk("beat_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk("beat_abcd", bus.sol_abcd, exp_q[0]);
          if (ready_always)
            chk("beat_time", cyc - t_acc, 2 + int'(bus.sol_abcd));
          if (bus.sol_ready) begin
            void'(exp_q.pop_front());
            popped++;
            obs_map[bus.sol_abcd] = 1'b1;
          end
        end
      end
      prev_hold = bus.sol_valid && !bus.sol_ready;
      prev_abcd = bus.sol_abcd;
      if (bus.done) begin
        chk("done_busy", busy, 1);
        chk("done_drained", exp_q.size(), 0);
        chk("done_sol_valid", bus.sol_valid, 0);
        if (ready_always)
          chk("done_time", cyc - t_acc, 18);
        busy = 0;
        done_seen++;
      end
      if (bus.req_valid && bus.req_ready) begin
        t_acc = cyc;
        mp = model_map(bus.target, bus.mask);
        exp_q.delete();
        for (int k = 0; k < 16; k++)
          if (mp[k]) exp_q.push_back(4'(k));
        popped  = 0;
        obs_map = '0;
        busy    = 1;
      end
    end
  end

  // Consumer: always ready, or a stall script that holds
  // beat 3 for five cycles and then toggles.
  always @(posedge clk) begin
    #1;
    if (!stall_mode) begin
      stall_ph = 0;
      bus.sol_ready = 1'b1;
    end else if (stall_ph == 0) begin
      bus.sol_ready = 1'b1;
      if (bus.sol_valid && bus.sol_abcd == 4'h3) begin
        stall_ph = 1;
        scnt = 1;
        bus.sol_ready = 1'b0;
      end
    end else if (stall_ph == 1) begin
      if (scnt < 5) begin
        scnt++;
        bus.sol_ready = 1'b0;
      end else begin
        stall_ph = 2;
        bus.sol_ready = 1'b1;
      end
    end else begin
      bus.sol_ready = ~bus.sol_ready;
    end
  end

  task automatic run(
    input logic [4:0]  t,
    input logic [4:0]  m,
    input bit          stall,
    input int          extra_req,
    input logic [15:0] lit
  );
    int d0;
    int n;
    chk("model_pin", model_map(t, m), lit);
    @(posedge clk);
    #2;
    ready_always = !stall;
    stall_mode   = stall;
    d0 = done_seen;
    bus.target    = t;
    bus.mask      = m;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < extra_req; i++) begin
      @(posedge clk);
      #2;
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (done_seen == d0 && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("done_timeout", done_seen != d0, 1);
    @(posedge clk);
    #2;
    chk("obs_map", obs_map, lit);
    stall_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.target    = '0;
    bus.mask      = '0;
    bus.sol_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(5'b00010, 5'b00010, 0, 0, 16'h0003);
    run(5'b11101, 5'b11111, 0, 2, 16'h0220);
    run(5'b00000, 5'b00000, 0, 0, 16'hFFFF);
    run(5'b01010, 5'b01010, 0, 0, 16'h0000);
    run(5'b00000, 5'b00000, 1, 0, 16'hFFFF);

    // Reset in the middle of a scan.
    @(posedge clk);
    #2;
    ready_always  = 1;
    bus.target    = 5'b00000;
    bus.mask      = 5'b00000;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #2;
    bus.req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run(5'b11101, 5'b11111, 0, 0, 16'h0220);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             n_checks, n_fail);
    $finish;
  end

endmodule
